// File: rtl/cpu_timer_regs.sv
// cpu_timer_regs: CPU-mapped down-counting timer with prescaler, sticky status and IRQ.
// Define TIMER_CAPTURE_EN to add the synchronized capture input and CAPTURE register.
module cpu_timer_regs #(
   parameter int unsigned BaseAddress   = 32'h9200,
   parameter int unsigned address_width = 16,
   parameter int unsigned data_width    = 32
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic [address_width-1:0] address_i,
   input  logic [data_width-1:0]    data_i,
   input  logic                     we_i,
   output logic [data_width-1:0]    data_o,
   output logic                     irq_o,
   input  logic                     capture_i
);

   localparam int unsigned RegW = 32;
   localparam int unsigned PreW = 16;
`ifdef TIMER_CAPTURE_EN
   localparam int unsigned WindowBytes = 24;
   localparam logic [2:0]  SelCapture  = 3'd5;
`else
   localparam int unsigned WindowBytes = 20;
`endif
   localparam logic [2:0]  SelCtrl     = 3'd0;
   localparam logic [2:0]  SelLoad     = 3'd1;
   localparam logic [2:0]  SelCount    = 3'd2;
   localparam logic [2:0]  SelStatus   = 3'd3;
   localparam logic [2:0]  SelPrescale = 3'd4;

   logic                     en_q, autoreload_q, irqen_q;
   logic [RegW-1:0]          load_q, count_q;
   logic                     expired_q, captured_q;
   logic [PreW-1:0]          prescale_q, presc_cnt_q;

   logic [address_width-1:0] offset;
   logic                     in_window;
   logic [2:0]               sel;
   logic [RegW-1:0]          wdata;
   logic                     wr_ctrl, wr_load, wr_status, wr_prescale;
   logic                     tick, expire, en_rise, cap_event;
   logic [RegW-1:0]          rd_data;

   // Address decode relative to the window base; addresses below base wrap out of range
   assign offset      = address_i - address_width'(BaseAddress);
   assign in_window   = offset < address_width'(WindowBytes);
   assign sel         = offset[4:2];
   assign wdata       = RegW'(data_i);

   assign wr_ctrl     = we_i & in_window & (sel == SelCtrl);
   assign wr_load     = we_i & in_window & (sel == SelLoad);
   assign wr_status   = we_i & in_window & (sel == SelStatus);
   assign wr_prescale = we_i & in_window & (sel == SelPrescale);

   // Tick once the prescaler reaches its limit; >= keeps it safe if PRESCALE shrinks mid-run
   assign tick        = en_q & (presc_cnt_q >= prescale_q);
   assign expire      = tick & (count_q == '0);
   assign en_rise     = wr_ctrl & wdata[0] & ~en_q;

`ifdef TIMER_CAPTURE_EN
   logic [2:0]      cap_sync_q;
   logic [RegW-1:0] capture_q;

   // Two synchronizer flops plus one history flop for rising-edge detection
   assign cap_event = cap_sync_q[1] & ~cap_sync_q[2];

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cap_sync_q <= '0;
         capture_q  <= '0;
      end else begin
         cap_sync_q <= {cap_sync_q[1:0], capture_i};
         if (cap_event) capture_q <= count_q;
      end
   end
`else
   logic unused_capture;
   assign unused_capture = capture_i;
   assign cap_event      = 1'b0;
`endif

   always_comb begin
      rd_data = '0;
      case (sel)
         SelCtrl:     rd_data = RegW'({irqen_q, autoreload_q, en_q});
         SelLoad:     rd_data = load_q;
         SelCount:    rd_data = count_q;
         SelStatus:   rd_data = RegW'({captured_q, expired_q});
         SelPrescale: rd_data = RegW'(prescale_q);
`ifdef TIMER_CAPTURE_EN
         SelCapture:  rd_data = capture_q;
`endif
         default:     rd_data = '0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         en_q         <= 1'b0;
         autoreload_q <= 1'b0;
         irqen_q      <= 1'b0;
         load_q       <= '0;
         count_q      <= '0;
         expired_q    <= 1'b0;
         captured_q   <= 1'b0;
         prescale_q   <= '0;
         presc_cnt_q  <= '0;
         irq_o        <= 1'b0;
         data_o       <= '0;
      end else begin
         if (wr_ctrl) begin
            en_q         <= wdata[0];
            autoreload_q <= wdata[1];
            irqen_q      <= wdata[2];
         end
         // One-shot expiry stops the timer regardless of a concurrent CTRL write
         if (expire && !autoreload_q) en_q <= 1'b0;

         if (wr_load)     load_q     <= wdata;
         if (wr_prescale) prescale_q <= wdata[PreW-1:0];

         if (en_rise) begin
            presc_cnt_q <= '0;
            count_q     <= load_q;
         end else if (tick) begin
            presc_cnt_q <= '0;
            if (count_q != '0)     count_q <= count_q - RegW'(1);
            else if (autoreload_q) count_q <= load_q;
         end else if (en_q) begin
            presc_cnt_q <= presc_cnt_q + PreW'(1);
         end

         // Set events beat a simultaneous write-1-to-clear
         expired_q  <= (expired_q  & ~(wr_status & wdata[0])) | expire;
         captured_q <= (captured_q & ~(wr_status & wdata[1])) | cap_event;

         irq_o  <= irqen_q & (expired_q | captured_q);
         data_o <= in_window ? data_width'(rd_data) : '0;
      end
   end

endmodule
